// File: rtl/vram_dump.sv
// Sequential VRAM range reader streaming nametable bytes over a valid/ready byte stream.
// Define VRAM_DUMP_ATR_EN to follow each nametable byte with its attribute nibble {4'h0, atr}.
module vram_dump #(
    parameter int AW = 11,
    parameter int LW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] ram_addr,
    output logic          ram_re,
    input  logic [7:0]    ram_dout,
    input  logic [3:0]    atr_dout,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_SEND_N = 3'd3;
`ifdef VRAM_DUMP_ATR_EN
    localparam logic [2:0] S_SEND_A = 3'd4;
`endif

    logic [2:0]    r_state;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_cnt;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_busy;
    logic          r_done;
    logic          w_hs;
    logic          w_adv;
    logic          w_last;

    assign w_hs   = r_tx_valid && tx_ready;
    assign w_last = (r_cnt == LW'(1));

`ifdef VRAM_DUMP_ATR_EN
    logic [3:0] r_atr_q;
    // A location is finished only once its attribute byte has been taken.
    assign w_adv = w_hs && (r_state == S_SEND_A);
`else
    logic [3:0] w_unused_atr;
    assign w_unused_atr = atr_dout;
    assign w_adv = w_hs && (r_state == S_SEND_N);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef VRAM_DUMP_ATR_EN
            r_atr_q    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_tx_valid <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_adv) begin
                r_addr     <= r_addr + AW'(1);
                r_cnt      <= r_cnt - LW'(1);
                r_tx_valid <= 1'b0;
                if (w_last) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end else begin
                    r_state <= S_FETCH;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_addr  <= base;
                            // len of zero selects the full 2^AW range
                            r_cnt   <= (len == '0) ? (LW'(1) << AW) : len;
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                    S_FETCH: r_state <= S_LATCH;
                    S_LATCH: begin
                        r_tx_data  <= ram_dout;
`ifdef VRAM_DUMP_ATR_EN
                        r_atr_q    <= atr_dout;
`endif
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND_N;
                    end
`ifdef VRAM_DUMP_ATR_EN
                    S_SEND_N: begin
                        if (w_hs) begin
                            r_tx_data <= {4'h0, r_atr_q};
                            r_state   <= S_SEND_A;
                        end
                    end
                    S_SEND_A: r_state <= S_SEND_A;
`else
                    S_SEND_N: r_state <= S_SEND_N;
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_re   = (r_state == S_FETCH);
    assign ram_addr = r_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_vram_dump.sv
// Scoreboard bench for vram_dump: a RAM model feeds the DUT, expected bytes and
// addresses are queued at start and popped on each handshake / read strobe.
module tb_vram_dump;
    localparam int AW = 11;
    localparam int LW = 12;
`ifdef VRAM_DUMP_ATR_EN
    localparam int BPL = 2;
`else
    localparam int BPL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tx_ready = 1'b1;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic [7:0]    ram_dout = '0;
    logic [3:0]    atr_dout = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;

    logic [7:0]    mem [0:2047];
    logic [3:0]    atr [0:2047];
    int            n_chk = 0;
    int            n_fail = 0;
    int            hs_cnt = 0;
    int            done_cnt = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    rx_log [$];
    logic [AW-1:0] addr_q [$];
    logic [AW-1:0] last_addr = '0;

    always #5 clk = ~clk;

    vram_dump #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base(base), .len(len),
        .ram_addr(ram_addr), .ram_re(ram_re), .ram_dout(ram_dout), .atr_dout(atr_dout),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    // synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_re) begin
            ram_dout <= mem[ram_addr];
            atr_dout <= atr[ram_addr];
        end
    end

    // stream / address monitor, sampled mid-cycle
    initial begin
        logic pv, pr, pa;
        logic [7:0] pd, e;
        logic [AW-1:0] ea;
        pv = 0; pr = 0; pa = 1; pd = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_valid && tx_ready) begin
                    hs_cnt++;
                    rx_log.push_back(tx_data);
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_byte: got unexpected byte %02h, queue empty", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            n_fail++;
                            $display("FAIL sb_byte: got %02h want %02h", tx_data, e);
                        end
                    end
                end
                if (ram_re) begin
                    last_addr = ram_addr;
                    n_chk++;
                    if (addr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_addr: got unexpected read at %03h", ram_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        if (ram_addr !== ea) begin
                            n_fail++;
                            $display("FAIL sb_addr: got %03h want %03h", ram_addr, ea);
                        end
                    end
                end
                if (pv && !pr && !pa) begin
                    n_chk++;
                    if (tx_valid !== 1'b1 || tx_data !== pd) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b d=%02h want v=1 d=%02h", tx_valid, tx_data, pd);
                    end
                end
                if (done) begin
                    done_cnt++;
                    n_chk++;
                    if (busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done_busy: got busy=%b want 0 in done cycle", busy);
                    end
                end
            end
            pv = tx_valid; pr = tx_ready; pa = abort || !rst_n; pd = tx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
        int n;
        logic [AW-1:0] a;
        n = (l == 0) ? (1 << AW) : int'(l);
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back(mem[a]);
            if (BPL == 2) exp_q.push_back({4'h0, atr[a]});
        end
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base = AW'($urandom); len = LW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int limit, input string nm);
        int c;
        c = 0;
        while (done_cnt == d0 && c < limit) begin
            @(negedge clk); #2;
            c++;
        end
        n_chk++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_done: no done pulse within %0d cycles", nm, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({ram_addr, ram_re, tx_data, tx_valid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got addr=%03h re=%b d=%02h v=%b busy=%b done=%b want all 0",
                     ram_addr, ram_re, tx_data, tx_valid, busy, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int d0, h0;
        d0 = done_cnt; h0 = hs_cnt; rx_log.delete();
        do_start(11'h000, 12'd4);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || ram_re !== 1'b1 || tx_valid !== 1'b0 || ram_addr !== 11'h000) begin
            n_fail++;
            $display("FAIL basic_fetch: got busy=%b re=%b v=%b addr=%03h want 1 1 0 000", busy, ram_re, tx_valid, ram_addr);
        end
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b0 || ram_re !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latch: got v=%b re=%b want 0 0", tx_valid, ram_re);
        end
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_first: got v=%b d=%02h want 1 00", tx_valid, tx_data);
        end
        wait_done(d0, 100, "basic");
        n_chk++;
        if (busy !== 1'b0 || hs_cnt - h0 != 4 * BPL) begin
            n_fail++;
            $display("FAIL basic_end: got busy=%b hs=%0d want 0 %0d", busy, hs_cnt - h0, 4 * BPL);
        end
        n_chk++;
        if (rx_log[0] !== 8'h00 || rx_log[BPL] !== 8'h01 || rx_log[2*BPL] !== 8'h02 || rx_log[3*BPL] !== 8'h03) begin
            n_fail++;
            $display("FAIL basic_stream: got %02h %02h %02h %02h want 00 01 02 03",
                     rx_log[0], rx_log[BPL], rx_log[2*BPL], rx_log[3*BPL]);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulse: got done=%b pulses=%0d want 0 1", done, done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        int d0;
        d0 = done_cnt; rx_log.delete();
        do_start(11'h7FE, 12'd4);
        wait_done(d0, 100, "wrap");
        n_chk++;
        if (last_addr !== 11'h001 || addr_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_end: got last=%03h aq=%0d eq=%0d want 001 0 0", last_addr, addr_q.size(), exp_q.size());
        end
        n_chk++;
        if (rx_log[0] !== 8'hFE || rx_log[BPL] !== 8'hFF || rx_log[2*BPL] !== 8'h00 || rx_log[3*BPL] !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_stream: got %02h %02h %02h %02h want FE FF 00 01",
                     rx_log[0], rx_log[BPL], rx_log[2*BPL], rx_log[3*BPL]);
        end
    endtask

    task automatic test_full();
        int d0, h0;
        d0 = done_cnt; h0 = hs_cnt;
        do_start(11'h123, 12'd0);
        wait_done(d0, 10000, "full");
        n_chk++;
        if (hs_cnt - h0 != 2048 * BPL || last_addr !== 11'h122) begin
            n_fail++;
            $display("FAIL full_count: got hs=%0d last=%03h want %0d 122", hs_cnt - h0, last_addr, 2048 * BPL);
        end
    endtask

    task automatic test_stall();
        int d0, h0, stall;
        d0 = done_cnt; h0 = hs_cnt; stall = 0;
        do_start(11'h000, 12'd4);
        for (int c = 0; c < 200 && done_cnt == d0; c++) begin
            @(posedge clk); #1;
            if (tx_valid && tx_data == 8'h02 && stall < 5) begin
                tx_ready = 1'b0;
                stall++;
                @(negedge clk);
                n_chk++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
                    n_fail++;
                    $display("FAIL stall_byte: got v=%b d=%02h want 1 02", tx_valid, tx_data);
                end
            end else begin
                tx_ready = 1'b1;
            end
        end
        tx_ready = 1'b1;
        n_chk++;
        if (done_cnt - d0 != 1 || hs_cnt - h0 != 4 * BPL || stall != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_end: got done=%0d hs=%0d stalls=%0d left=%0d want 1 %0d 5 0",
                     done_cnt - d0, hs_cnt - h0, stall, exp_q.size(), 4 * BPL);
        end
    endtask

    task automatic test_abort();
        int d0, h0, c;
        d0 = done_cnt; h0 = hs_cnt; c = 0;
        do_start(11'h000, 12'd8);
        while (hs_cnt - h0 < 2 && c < 100) begin
            @(negedge clk); #2;
            c++;
        end
        n_chk++;
        if (hs_cnt - h0 < 2) begin
            n_fail++;
            $display("FAIL abort_wait: got %0d handshakes want 2", hs_cnt - h0);
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete(); addr_q.delete();
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: got v=%b busy=%b want 0 0", tx_valid, busy);
        end
        repeat (6) @(negedge clk);
        #2;
        n_chk++;
        if (done_cnt != d0 || hs_cnt - h0 != 2) begin
            n_fail++;
            $display("FAIL abort_quiet: got done=%0d hs=%0d want 0 2", done_cnt - d0, hs_cnt - h0);
        end
        // start together with abort must not launch a dump
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base = 11'h005; len = 12'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || ram_re !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins: got busy=%b re=%b want 0 0", busy, ram_re);
        end
        h0 = hs_cnt; d0 = done_cnt; rx_log.delete();
        do_start(11'h010, 12'd1);
        wait_done(d0, 100, "abort_restart");
        n_chk++;
        if (hs_cnt - h0 != BPL || rx_log[0] !== mem[16]) begin
            n_fail++;
            $display("FAIL abort_restart: got hs=%0d b0=%02h want %0d %02h", hs_cnt - h0, rx_log[0], BPL, mem[16]);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        do_start(11'h000, 12'd8);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ram_addr, ram_re, tx_data, tx_valid, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got addr=%03h re=%b d=%02h v=%b busy=%b done=%b want all 0",
                     ram_addr, ram_re, tx_data, tx_valid, busy, done);
        end
        exp_q.delete(); addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        n_chk++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nodone: got done=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_atr();
        int d0;
        logic [7:0] want [$];
        mem[16] = 8'h41; mem[17] = 8'h42;
        atr[16] = 4'h5;  atr[17] = 4'hA;
        if (BPL == 2) want = '{8'h41, 8'h05, 8'h42, 8'h0A};
        else          want = '{8'h41, 8'h42};
        d0 = done_cnt; rx_log.delete();
        do_start(11'h010, 12'd2);
        wait_done(d0, 100, "atr");
        n_chk++;
        if (rx_log.size() != want.size()) begin
            n_fail++;
            $display("FAIL atr_len: got %0d bytes want %0d", rx_log.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                n_chk++;
                if (rx_log[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL atr_byte%0d: got %02h want %02h", i, rx_log[i], want[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'(i);
            atr[i] = 4'(i);
        end
        test_reset();
        test_basic();
        test_wrap();
        test_full();
        test_stall();
        test_abort();
        test_reset_mid();
        test_atr();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
